t07_mem_sequencer: RTL
======================

Name: t07_mem_sequencer

Overview:
Parametrised next-generation memory access sequencer for the t07 CPU. It runs the instruction-fetch / load / store sequence against the external MMIO bus using a busy falling-edge handshake, and freezes the CPU while the bus is in use. Beyond the previous generation it adds byte-lane alignment with byte enables, misalignment faults, a store completion path and an optional bus watchdog. It sits between the CPU datapath (ALU address, register/FPU data, writeback mux) and the MMIO arbiter.

Parameters:
ADDR_W, 32, width of addrMMIO_o and ALU_address
TIMEOUT, 1023, max cycles allowed in any bus-wait state before fault (watchdog build only)
TO_W, $clog2(TIMEOUT+1), watchdog counter width (derived, not overridden)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
busy_i  in  1  MMIO busy; a transaction completes on its falling edge
memOp  in  4  1=LB 2=LH 3=LW 4=LBU 5=LHU 6=SB 7=SH 8=SW; other values invalid
memWrite  in  1  current instruction is a store
memRead  in  1  current instruction is a load
memSource  in  1  store data source: 1=FPU_data_i, 0=regData_i
ALU_address  in  ADDR_W  effective load/store address
FPU_data_i  in  32  FPU register store data
regData_i  in  32  integer register store data
dataMMIO_i  in  32  bus read data (word-aligned)
dataMMIO_o  out  32  bus write data, lane-shifted
addrMMIO_o  out  ADDR_W  word-aligned bus address ({ALU_address[ADDR_W-1:2],2'b00})
byteEn_o  out  4  active byte lanes
regData_o  out  32  registered load result
freeze_o  out  1  1 = hold PC/pipeline
rwi  out  2  00 idle, 01 write, 10 read, 11 fetch
addrControl  out  1  1 = fetch address (PC), 0 = load/store address
state_o  out  4  current state encoding
fault_o  out  1  one-cycle pulse on fault
faultCause_o  out  2  00 none, 01 misaligned, 10 bad memOp, 11 timeout; sticky until next fault or reset

Behaviour:
- Reset (async, nrst=0): state=INC, regData_o=0, faultCause_o=00, busy_q=0, watchdog=0. All outputs take INC-state values.
- busy_edge = ~busy_i & busy_q, where busy_q is busy_i registered.
- States (encoding): INC 0, FETCH 1, F_WAIT 2, DECODE 3, LOAD 4, LOAD_WAIT 5, STORE 6, STORE_WAIT 7, FAULT 8.
- INC: freeze_o=0 (only unfrozen state), rwi=11, addrControl=1. -> FETCH.
- FETCH: freeze_o=1, rwi=11, addrControl=1. Stays until busy_edge -> F_WAIT.
- F_WAIT: rwi=11. -> DECODE after 1 cycle.
- DECODE: rwi=00, addrControl=1. memWrite has priority over memRead. Check the request: invalid memOp for the direction -> FAULT (10); halfword with addr[0]=1 or word with addr[1:0]!=0 -> FAULT (01); otherwise memWrite -> STORE, memRead -> LOAD, neither -> INC.
- LOAD: rwi=10, addrControl=0, byteEn_o from size and offset. On busy_edge, capture into regData_o: lane=dataMMIO_i >> (8*addr[1:0]), then sign- or zero-extend per memOp. -> LOAD_WAIT.
- LOAD_WAIT: rwi=10, regData_o held. -> INC.
- STORE: rwi=01, addrControl=0. dataMMIO_o = source data (low byte/half/word) << (8*addr[1:0]). byteEn_o: SB 0001<<off, SH 0011<<off, SW 1111. On busy_edge -> STORE_WAIT.
- STORE_WAIT: rwi=00. -> INC.
- FAULT: rwi=00, freeze_o=1, fault_o=1 for this single cycle, no bus access. -> INC.
- Outside LOAD/STORE: byteEn_o=0, dataMMIO_o=0, addrMMIO_o=0.
- regData_o changes only on a LOAD capture.
- busy_edge is ignored in states that do not wait on the bus.
- Reset asserted mid-transaction aborts immediately to INC; no partial write is retried.

Optional Feature:
T07_MEM_TIMEOUT_EN:
- Defined: a counter clears on entry to FETCH, LOAD or STORE and increments each cycle in that state. Reaching TIMEOUT without busy_edge -> FAULT with cause 11. The fetch is abandoned and regData_o is unchanged.
- Undefined: no counter; wait states wait indefinitely. Cause 11 is never produced.

Test Plan:
- Reset, then fetch with busy pulsed high 3 cycles: state sequence INC,FETCH,...,F_WAIT,DECODE,INC; freeze_o=0 only in INC; rwi=11 during fetch.
- LB at addr 0x1003, dataMMIO_i=0x80AB_CDEF: byteEn_o=1000, addrMMIO_o=0x1000, regData_o=0xFFFF_FF80. Repeat as LBU: 0x0000_0080.
- SH from regData_i=0x1234_5678 at addr 0x2002: rwi=01, byteEn_o=1100, dataMMIO_o=0x5678_0000; after busy_edge -> STORE_WAIT -> INC.
- SW from FPU (memSource=1, FPU_data_i=0x3F80_0000) at 0x2000: dataMMIO_o=0x3F80_0000, byteEn_o=1111.
- LW at 0x2001: DECODE -> FAULT, fault_o pulses once, faultCause_o=01, no rwi=10 cycle, regData_o unchanged. memRead with memOp=7 -> faultCause_o=10.
- With T07_MEM_TIMEOUT_EN, TIMEOUT=8, busy_i stuck 1 in LOAD: FAULT after 8 cycles, faultCause_o=11. Separately, assert nrst mid-STORE: outputs return to reset values immediately.

Source files
------------

// File: rtl/t07_mem_sequencer.sv
// t07_mem_sequencer: memory access sequencer for the t07 CPU.
//
// Runs the instruction-fetch / load / store sequence against the external MMIO
// bus. A bus transaction completes on the falling edge of busy_i. The CPU is
// frozen in every state except INC. Loads and stores are lane-aligned with
// byte enables. Misaligned or invalid requests raise a one-cycle fault with a
// sticky cause code.
//
// Optional build macro:
//   T07_MEM_TIMEOUT_EN - adds a bus watchdog. Any bus-wait state (FETCH, LOAD,
//                        STORE) that lasts TIMEOUT cycles without a busy falling
//                        edge goes to FAULT with cause 11.
//
// Parameters:
//   ADDR_W   width of ALU_address / addrMMIO_o
//   TIMEOUT  watchdog limit in cycles (watchdog build only)
//   TO_W     watchdog counter width (derived)
//
// Ports:
//   clk, nrst         clock, asynchronous active-low reset
//   busy_i            MMIO busy, transaction completes on its falling edge
//   memOp             1=LB 2=LH 3=LW 4=LBU 5=LHU 6=SB 7=SH 8=SW
//   memWrite/memRead  store / load request (memWrite has priority)
//   memSource         store data source: 1=FPU_data_i, 0=regData_i
//   ALU_address       effective load/store address
//   FPU_data_i        FPU store data
//   regData_i         integer register store data
//   dataMMIO_i        bus read data (word aligned)
//   dataMMIO_o        bus write data, lane shifted
//   addrMMIO_o        word-aligned bus address (LOAD/STORE only)
//   byteEn_o          active byte lanes (LOAD/STORE only)
//   regData_o         registered load result
//   freeze_o          hold PC/pipeline
//   rwi               00 idle, 01 write, 10 read, 11 fetch
//   addrControl       1 = fetch address (PC), 0 = load/store address
//   state_o           current state encoding
//   fault_o           one-cycle fault pulse
//   faultCause_o      00 none, 01 misaligned, 10 bad memOp, 11 timeout

module t07_mem_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              busy_i,
    input  logic [3:0]        memOp,
    input  logic              memWrite,
    input  logic              memRead,
    input  logic              memSource,
    input  logic [ADDR_W-1:0] ALU_address,
    input  logic [31:0]       FPU_data_i,
    input  logic [31:0]       regData_i,
    input  logic [31:0]       dataMMIO_i,
    output logic [31:0]       dataMMIO_o,
    output logic [ADDR_W-1:0] addrMMIO_o,
    output logic [3:0]        byteEn_o,
    output logic [31:0]       regData_o,
    output logic              freeze_o,
    output logic [1:0]        rwi,
    output logic              addrControl,
    output logic [3:0]        state_o,
    output logic              fault_o,
    output logic [1:0]        faultCause_o
);

    typedef enum logic [3:0] {
        StInc       = 4'd0,
        StFetch     = 4'd1,
        StFWait     = 4'd2,
        StDecode    = 4'd3,
        StLoad      = 4'd4,
        StLoadWait  = 4'd5,
        StStore     = 4'd6,
        StStoreWait = 4'd7,
        StFault     = 4'd8
    } state_e;

    localparam logic [1:0] CauseNone  = 2'b00;
    localparam logic [1:0] CauseAlign = 2'b01;
    localparam logic [1:0] CauseOp    = 2'b10;
    localparam logic [1:0] CauseTime  = 2'b11;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    state_e      state_q, state_d;
    logic        busy_q;
    logic        busy_edge;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wd_expired;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [1:0]  off;
    logic [1:0]  size;
    logic        op_is_load;
    logic        op_is_store;
    logic        misaligned;
    logic [3:0]  lane_en;
    logic [31:0] rd_lane;
    logic [31:0] load_val;
    logic [31:0] st_src;
    logic [31:0] st_data;

    assign busy_edge = ~busy_i & busy_q;
    assign off       = ALU_address[1:0];

    always_comb begin
        op_is_load  = 1'b0;
        op_is_store = 1'b0;
        size        = SizeByte;
        case (memOp)
            4'd1, 4'd4: begin op_is_load  = 1'b1; size = SizeByte; end
            4'd2, 4'd5: begin op_is_load  = 1'b1; size = SizeHalf; end
            4'd3:       begin op_is_load  = 1'b1; size = SizeWord; end
            4'd6:       begin op_is_store = 1'b1; size = SizeByte; end
            4'd7:       begin op_is_store = 1'b1; size = SizeHalf; end
            4'd8:       begin op_is_store = 1'b1; size = SizeWord; end
            default:    size = SizeByte;
        endcase
    end

    assign misaligned = ((size == SizeHalf) && off[0]) ||
                        ((size == SizeWord) && (off != 2'b00));

    always_comb begin
        case (size)
            SizeHalf: lane_en = 4'b0011 << off;
            SizeWord: lane_en = 4'b1111;
            default:  lane_en = 4'b0001 << off;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend per memOp.
    assign rd_lane = dataMMIO_i >> {off, 3'b000};

    always_comb begin
        case (memOp)
            4'd1:    load_val = {{24{rd_lane[7]}}, rd_lane[7:0]};
            4'd2:    load_val = {{16{rd_lane[15]}}, rd_lane[15:0]};
            4'd4:    load_val = {24'h000000, rd_lane[7:0]};
            4'd5:    load_val = {16'h0000, rd_lane[15:0]};
            default: load_val = rd_lane;
        endcase
    end

    assign st_src = memSource ? FPU_data_i : regData_i;

    always_comb begin
        case (size)
            SizeHalf: st_data = {16'h0000, st_src[15:0]} << {off, 3'b000};
            SizeWord: st_data = st_src;
            default:  st_data = {24'h000000, st_src[7:0]} << {off, 3'b000};
        endcase
    end

    // ------------------------------------------------------------------
    // Optional bus watchdog
    // ------------------------------------------------------------------
`ifdef T07_MEM_TIMEOUT_EN
    logic [TO_W-1:0] wd_q, wd_d;
    logic            in_bus_wait;

    assign in_bus_wait = (state_q == StFetch) || (state_q == StLoad) ||
                         (state_q == StStore);
    assign wd_expired  = (wd_q == TO_W'(TIMEOUT - 1));

    // Outside the wait states the counter is held at zero, so it is already
    // clear on entry to FETCH/LOAD/STORE.
    always_comb begin
        wd_d = '0;
        if (in_bus_wait && !busy_edge) begin
            wd_d = wd_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic [63:0] unused_cfg;

    assign wd_expired = 1'b0;
    assign unused_cfg = {TIMEOUT, TO_W};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StInc;
            busy_q  <= 1'b0;
            cause_q <= CauseNone;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_i;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StInc: state_d = StFetch;
            StFetch: begin
                if (busy_edge) begin
                    state_d = StFWait;
                end else if (wd_expired) begin
                    state_d = StFault;
                    cause_d = CauseTime;
                end
            end
            StFWait: state_d = StDecode;
            StDecode: begin
                if (memWrite) begin
                    if (!op_is_store) begin
                        state_d = StFault;
                        cause_d = CauseOp;
                    end else if (misaligned) begin
                        state_d = StFault;
                        cause_d = CauseAlign;
                    end else begin
                        state_d = StStore;
                    end
                end else if (memRead) begin
                    if (!op_is_load) begin
                        state_d = StFault;
                        cause_d = CauseOp;
                    end else if (misaligned) begin
                        state_d = StFault;
                        cause_d = CauseAlign;
                    end else begin
                        state_d = StLoad;
                    end
                end else begin
                    state_d = StInc;
                end
            end
            StLoad: begin
                if (busy_edge) begin
                    rdata_d = load_val;
                    state_d = StLoadWait;
                end else if (wd_expired) begin
                    state_d = StFault;
                    cause_d = CauseTime;
                end
            end
            StLoadWait: state_d = StInc;
            StStore: begin
                if (busy_edge) begin
                    state_d = StStoreWait;
                end else if (wd_expired) begin
                    state_d = StFault;
                    cause_d = CauseTime;
                end
            end
            StStoreWait: state_d = StInc;
            StFault:     state_d = StInc;
            default:     state_d = StInc;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        freeze_o    = 1'b1;
        rwi         = 2'b00;
        addrControl = 1'b1;
        byteEn_o    = 4'b0000;
        dataMMIO_o  = 32'h0000_0000;
        addrMMIO_o  = '0;
        fault_o     = 1'b0;
        unique case (state_q)
            StInc: begin
                freeze_o = 1'b0;
                rwi      = 2'b11;
            end
            StFetch: rwi = 2'b11;
            StFWait: rwi = 2'b11;
            StDecode: rwi = 2'b00;
            StLoad: begin
                rwi         = 2'b10;
                addrControl = 1'b0;
                byteEn_o    = lane_en;
                addrMMIO_o  = {ALU_address[ADDR_W-1:2], 2'b00};
            end
            StLoadWait: begin
                rwi         = 2'b10;
                addrControl = 1'b0;
            end
            StStore: begin
                rwi         = 2'b01;
                addrControl = 1'b0;
                byteEn_o    = lane_en;
                dataMMIO_o  = st_data;
                addrMMIO_o  = {ALU_address[ADDR_W-1:2], 2'b00};
            end
            StStoreWait: addrControl = 1'b0;
            StFault: fault_o = 1'b1;
            default: rwi = 2'b00;
        endcase
    end

    assign state_o      = state_q;
    assign regData_o    = rdata_q;
    assign faultCause_o = cause_q;

endmodule
